snoop_bus_ctrl: RTL and testbench

// - Bus-side (snoop) half of the MSI coherence pair: consumes bus messages emitted by a remote

---
 rtl/snoop_bus_ctrl.sv | 176 +++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_bus_ctrl.sv
// Snoop side of an MSI pair: queues remote bus messages and applies one per cycle to local line states.
// Latency: a message accepted at edge N updates state and raises wb_valid/abort_mem at edge N+1.
// Backpressure: bus_ready = !fifo_full; a full FIFO refuses even when a pop happens the same cycle.
//
// Ports: KEY[0] clock, KEY[1] async active-low reset; bus_valid/bus_msg/bus_addr/bus_ready message
// input; loc_valid/loc_addr/loc_state local state writes; rd_addr/rd_state combinational readout;
// wb_valid/abort_mem/wb_addr write-back request; proto_err sticky protocol error.
// Optional macro SNOOP_STATS_EN adds saturating counters snoop_hits and wb_count.

// Generic single-clock FIFO; pop_dat is the head entry, valid whenever pop_vld is high.
module snoop_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    assign pop_vld  = (wr_ptr != rd_ptr);
    assign push_rdy = !((wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]));
    assign pop_dat  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_vld && push_rdy) wr_ptr <= wr_ptr + 1'b1;
            if (pop_vld && pop_rdy)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (push_vld && push_rdy) mem[wr_ptr[PW-1:0]] <= push_dat;
    end
endmodule

module snoop_bus_ctrl #(
    parameter int ADDR_W     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic [1:0]        KEY,
    input  logic              bus_valid,
    input  logic [2:0]        bus_msg,
    input  logic [ADDR_W-1:0] bus_addr,
    output logic              bus_ready,
    input  logic              loc_valid,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [1:0]        loc_state,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_state,
    output logic              wb_valid,
    output logic              abort_mem,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              proto_err
`ifdef SNOOP_STATS_EN
    ,
    output logic [7:0]        snoop_hits,
    output logic [7:0]        wb_count
`endif
);
    localparam int NUM_LINES = 2 ** ADDR_W;

    localparam logic [2:0] MSG_RD  = 3'b001;
    localparam logic [2:0] MSG_INV = 3'b010;
    localparam logic [2:0] MSG_WR  = 3'b011;

    typedef enum logic [1:0] {
        LN_I = 2'b00,
        LN_E = 2'b01,
        LN_S = 2'b10
    } line_st_e;

    typedef struct packed {
        logic [2:0]        msg;
        logic [ADDR_W-1:0] addr;
    } msg_t;

    logic     core_clk;
    logic     arst_n;
    assign core_clk = KEY[0];
    assign arst_n   = KEY[1];

    msg_t     in_ent;
    msg_t     head;
    logic     head_vld;
    line_st_e line_st [NUM_LINES];
    line_st_e cur_st;
    line_st_e snp_nxt;
    logic     snp_wb;
    logic     snp_err;

    assign in_ent.msg  = bus_msg;
    assign in_ent.addr = bus_addr;

    snoop_fifo #(.W($bits(msg_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .core_clk (core_clk),
        .arst_n   (arst_n),
        .push_vld (bus_valid),
        .push_rdy (bus_ready),
        .push_dat (in_ent),
        .pop_vld  (head_vld),
        .pop_rdy  (1'b1),
        .pop_dat  (head)
    );

    assign cur_st   = line_st[head.addr];
    assign rd_state = line_st[rd_addr];

    // Snoop reaction for the head message against the line's pre-edge state.
    always_comb begin
        snp_nxt = cur_st;
        snp_wb  = 1'b0;
        snp_err = 1'b0;
        case (head.msg)
            MSG_RD: begin
                if (cur_st == LN_E) begin
                    snp_nxt = LN_S;
                    snp_wb  = 1'b1;
                end
            end
            MSG_WR: begin
                snp_nxt = LN_I;
                snp_wb  = (cur_st == LN_E);
            end
            MSG_INV: begin
                // A remote invalidate should never find us Exclusive; keep the line and flag it.
                if (cur_st == LN_E) snp_err = 1'b1;
                else                snp_nxt = LN_I;
            end
            default: ;
        endcase
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < NUM_LINES; i++) line_st[i] <= LN_I;
            wb_valid  <= 1'b0;
            abort_mem <= 1'b0;
            wb_addr   <= '0;
            proto_err <= 1'b0;
        end else begin
            wb_valid  <= head_vld && snp_wb;
            abort_mem <= head_vld && snp_wb;
            if (head_vld && snp_wb)  wb_addr   <= head.addr;
            if (head_vld && snp_err) proto_err <= 1'b1;
            if (head_vld) line_st[head.addr] <= snp_nxt;
            // Local update is written last so it overrides a snoop on the same line.
            if (loc_valid && (loc_state != 2'b11)) line_st[loc_addr] <= line_st_e'(loc_state);
        end
    end

`ifdef SNOOP_STATS_EN
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            snoop_hits <= '0;
            wb_count   <= '0;
        end else begin
            if (head_vld && (cur_st != LN_I) && (snoop_hits != 8'hff)) snoop_hits <= snoop_hits + 8'd1;
            if (head_vld && snp_wb && (wb_count != 8'hff))             wb_count   <= wb_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Bench for snoop_bus_ctrl: directed scenarios plus randomized traffic checked against a queue model.
// Latency: model advances one clock per tick call; outputs sampled 1ns after the rising edge.
// Backpressure: model FIFO occupancy predicts bus_ready.
module tb_snoop_bus_ctrl;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       bus_valid;
    logic [2:0] bus_msg;
    logic [1:0] bus_addr;
    logic       bus_ready;
    logic       loc_valid;
    logic [1:0] loc_addr;
    logic [1:0] loc_state;
    logic [1:0] rd_addr;
    logic [1:0] rd_state;
    logic       wb_valid;
    logic       abort_mem;
    logic [1:0] wb_addr;
    logic       proto_err;
`ifdef SNOOP_STATS_EN
    logic [7:0] snoop_hits;
    logic [7:0] wb_count;
`endif

    snoop_bus_ctrl #(.ADDR_W(2), .FIFO_DEPTH(DEPTH)) dut (
        .KEY       ({rst_n, clk}),
        .bus_valid (bus_valid),
        .bus_msg   (bus_msg),
        .bus_addr  (bus_addr),
        .bus_ready (bus_ready),
        .loc_valid (loc_valid),
        .loc_addr  (loc_addr),
        .loc_state (loc_state),
        .rd_addr   (rd_addr),
        .rd_state  (rd_state),
        .wb_valid  (wb_valid),
        .abort_mem (abort_mem),
        .wb_addr   (wb_addr),
        .proto_err (proto_err)
`ifdef SNOOP_STATS_EN
        ,
        .snoop_hits(snoop_hits),
        .wb_count  (wb_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0] msg;
        logic [1:0] addr;
    } ent_t;

    // Behavioural model: message queue, line-state table, expected registered outputs.
    ent_t       q[$];
    logic [1:0] mst [4];
    logic       m_wb;
    logic [1:0] m_wbaddr;
    logic       m_perr;
    int         m_hits;
    int         m_wbc;
    int         n_tests;
    int         n_fail;

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) mst[i] = 2'b00;
        m_wb = 0; m_wbaddr = 0; m_perr = 0; m_hits = 0; m_wbc = 0;
    endtask

    // Advance model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        ent_t       e;
        ent_t       ne;
        logic [1:0] s;
        logic [1:0] ns;
        bit         wb;
        bit         acc;
        acc  = bus_valid && (q.size() < DEPTH);
        m_wb = 0;
        if (q.size() > 0) begin
            e  = q.pop_front();
            s  = mst[e.addr];
            ns = s;
            wb = 0;
            if (e.msg == 3'd1) begin
                if (s == 2'b01) begin ns = 2'b10; wb = 1; end
            end else if (e.msg == 3'd3) begin
                ns = 2'b00;
                wb = (s == 2'b01);
            end else if (e.msg == 3'd2) begin
                if (s == 2'b01) m_perr = 1;
                else            ns = 2'b00;
            end
            mst[e.addr] = ns;
            m_wb = wb;
            if (wb) m_wbaddr = e.addr;
            if (s != 2'b00 && m_hits < 255) m_hits++;
            if (wb && m_wbc < 255) m_wbc++;
        end
        if (loc_valid && loc_state != 2'b11) mst[loc_addr] = loc_state;
        if (acc) begin
            ne.msg = bus_msg; ne.addr = bus_addr;
            q.push_back(ne);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_valid = 0; bus_msg = 0; bus_addr = 0;
        loc_valid = 0; loc_addr = 0; loc_state = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic set_line(input logic [1:0] a, input logic [1:0] st);
        loc_valid = 1; loc_addr = a; loc_state = st;
        tick();
        loc_valid = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb: wb_valid=%b expected 0", wb_valid); end
        n_tests++; if (abort_mem !== 1'b0) begin n_fail++; $display("FAIL reset_abort: abort_mem=%b expected 0", abort_mem); end
        n_tests++; if (wb_addr !== 2'd0) begin n_fail++; $display("FAIL reset_wbaddr: wb_addr=%0d expected 0", wb_addr); end
        n_tests++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: proto_err=%b expected 0", proto_err); end
        n_tests++; if (bus_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: bus_ready=%b expected 1", bus_ready); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); #1;
            n_tests++; if (rd_state !== 2'b00) begin n_fail++; $display("FAIL reset_state: line %0d state=%b expected 00", i, rd_state); end
        end
    endtask

    task automatic test_read_miss_excl();
        set_line(2'd1, 2'b01);
        bus_valid = 1; bus_msg = 3'b001; bus_addr = 2'd1; rd_addr = 2'd1;
        tick();
        bus_valid = 0;
        n_tests++; if (rd_state !== 2'b01 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rdmiss_latency: state=%b wb_valid=%b expected 01 0", rd_state, wb_valid); end
        tick();
        n_tests++; if (rd_state !== 2'b10) begin n_fail++; $display("FAIL rdmiss_state: state=%b expected 10", rd_state); end
        n_tests++; if (wb_valid !== 1'b1 || abort_mem !== 1'b1) begin n_fail++; $display("FAIL rdmiss_pulse: wb_valid=%b abort_mem=%b expected 1 1", wb_valid, abort_mem); end
        n_tests++; if (wb_addr !== 2'd1) begin n_fail++; $display("FAIL rdmiss_addr: wb_addr=%0d expected 1", wb_addr); end
        tick();
        n_tests++; if (wb_valid !== 1'b0 || abort_mem !== 1'b0) begin n_fail++; $display("FAIL rdmiss_oneshot: wb_valid=%b abort_mem=%b expected 0 0", wb_valid, abort_mem); end
        n_tests++; if (wb_addr !== 2'd1) begin n_fail++; $display("FAIL rdmiss_hold: wb_addr=%0d expected 1", wb_addr); end
    endtask

    task automatic test_invalidate();
        set_line(2'd2, 2'b10);
        bus_valid = 1; bus_msg = 3'b010; bus_addr = 2'd2; rd_addr = 2'd2;
        tick();
        bus_valid = 0;
        tick();
        n_tests++; if (rd_state !== 2'b00 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL inv_shared: state=%b wb_valid=%b expected 00 0", rd_state, wb_valid); end
        set_line(2'd2, 2'b01);
        bus_valid = 1;
        tick();
        bus_valid = 0;
        tick();
        n_tests++; if (rd_state !== 2'b01 || proto_err !== 1'b1) begin n_fail++; $display("FAIL inv_excl: state=%b proto_err=%b expected 01 1", rd_state, proto_err); end
        repeat (3) tick();
        n_tests++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL inv_sticky: proto_err=%b expected 1", proto_err); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] msgs [5];
        logic [1:0] adrs [5];
        int         exp_wb [6];
        int         exp_ad [6];
        logic [1:0] exp_fin [4];
        msgs = '{3'd1, 3'd3, 3'd2, 3'd1, 3'd3};
        adrs = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_wb = '{0, 1, 1, 0, 1, 0};
        exp_ad = '{0, 0, 1, 0, 3, 0};
        exp_fin = '{2'b00, 2'b00, 2'b00, 2'b10};
        set_line(2'd0, 2'b01);
        set_line(2'd1, 2'b01);
        set_line(2'd2, 2'b10);
        set_line(2'd3, 2'b01);
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                bus_valid = 1; bus_msg = msgs[k]; bus_addr = adrs[k];
                n_tests++; if (bus_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: msg %0d bus_ready=%b expected 1", k, bus_ready); end
            end else begin
                bus_valid = 0;
            end
            tick();
            n_tests++; if (wb_valid !== 1'(exp_wb[k])) begin n_fail++; $display("FAIL b2b_wb: edge %0d wb_valid=%b expected %0d", k, wb_valid, exp_wb[k]); end
            if (exp_wb[k] == 1) begin
                n_tests++; if (wb_addr !== 2'(exp_ad[k])) begin n_fail++; $display("FAIL b2b_addr: edge %0d wb_addr=%0d expected %0d", k, wb_addr, exp_ad[k]); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); #1;
            n_tests++; if (rd_state !== exp_fin[i]) begin n_fail++; $display("FAIL b2b_final: line %0d state=%b expected %b", i, rd_state, exp_fin[i]); end
        end
    endtask

    task automatic test_same_edge();
        set_line(2'd0, 2'b01);
        bus_valid = 1; bus_msg = 3'b011; bus_addr = 2'd0; rd_addr = 2'd0;
        tick();
        bus_valid = 0;
        loc_valid = 1; loc_addr = 2'd0; loc_state = 2'b10;
        tick();
        loc_valid = 0;
        n_tests++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL same_edge_wb: wb_valid=%b expected 1", wb_valid); end
        n_tests++; if (rd_state !== 2'b10) begin n_fail++; $display("FAIL same_edge_state: state=%b expected 10", rd_state); end
    endtask

    task automatic test_reset_mid();
        set_line(2'd0, 2'b01);
        set_line(2'd1, 2'b01);
        set_line(2'd2, 2'b01);
        for (int k = 0; k < 3; k++) begin
            bus_valid = 1; bus_msg = 3'b001; bus_addr = 2'(k);
            tick();
        end
        idle_inputs();
        rst_n = 0;
        model_reset();
        #2;
        n_tests++; if (wb_valid !== 1'b0 || abort_mem !== 1'b0) begin n_fail++; $display("FAIL midrst_pulse: wb_valid=%b abort_mem=%b expected 0 0", wb_valid, abort_mem); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i); #1;
            n_tests++; if (rd_state !== 2'b00) begin n_fail++; $display("FAIL midrst_state: line %0d state=%b expected 00", i, rd_state); end
        end
        @(posedge clk); #1;
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++; if (wb_valid !== 1'b0 || bus_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_after: cycle %0d wb_valid=%b bus_ready=%b expected 0 1", k, wb_valid, bus_ready); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus_valid = 1'($urandom_range(0, 1));
            bus_msg   = 3'($urandom_range(0, 7));
            bus_addr  = 2'($urandom_range(0, 3));
            loc_valid = 1'($urandom_range(0, 1));
            loc_addr  = 2'($urandom_range(0, 3));
            loc_state = 2'($urandom_range(0, 3));
            rd_addr   = 2'($urandom_range(0, 3));
            n_tests++; if (bus_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready: cycle %0d bus_ready=%b expected %b", c, bus_ready, q.size() < DEPTH); end
            tick();
            n_tests++; if (wb_valid !== m_wb || abort_mem !== m_wb) begin n_fail++; $display("FAIL rnd_wb: cycle %0d wb_valid=%b abort_mem=%b expected %b", c, wb_valid, abort_mem, m_wb); end
            n_tests++; if (wb_addr !== m_wbaddr) begin n_fail++; $display("FAIL rnd_wbaddr: cycle %0d wb_addr=%0d expected %0d", c, wb_addr, m_wbaddr); end
            n_tests++; if (proto_err !== m_perr) begin n_fail++; $display("FAIL rnd_perr: cycle %0d proto_err=%b expected %b", c, proto_err, m_perr); end
            n_tests++; if (rd_state !== mst[rd_addr]) begin n_fail++; $display("FAIL rnd_state: cycle %0d line %0d state=%b expected %b", c, rd_addr, rd_state, mst[rd_addr]); end
        end
        idle_inputs();
    endtask

`ifdef SNOOP_STATS_EN
    task automatic test_stats();
        apply_reset();
        loc_valid = 1; loc_addr = 2'd0; loc_state = 2'b01;
        bus_valid = 1; bus_msg = 3'b001; bus_addr = 2'd0;
        repeat (302) tick();
        idle_inputs();
        tick();
        n_tests++; if (wb_count !== 8'd255) begin n_fail++; $display("FAIL stats_wb: wb_count=%0d expected 255", wb_count); end
        n_tests++; if (snoop_hits !== 8'(m_hits)) begin n_fail++; $display("FAIL stats_hits: snoop_hits=%0d expected %0d", snoop_hits, m_hits); end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rd_addr = 0;
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_read_miss_excl();
        test_invalidate();
        test_back_to_back();
        test_same_edge();
        test_reset_mid();
        test_random();
`ifdef SNOOP_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
